// File: rtl/control_sequencer_if.sv
// rtl/control_sequencer_if.sv - opcode in, T-state and bus control strobes out of the sequencer
interface control_sequencer_if;
   logic [3:0] opcode;
   logic [2:0] step;
   logic       halted;
   logic       hlt;
   logic       mi_n;
   logic       ri_n;
   logic       ro_n;
   logic       ii_n;
   logic       io_n;
   logic       ai_n;
   logic       ao_n;
   logic       eo_n;
   logic       su;
   logic       bi_n;
   logic       oi_n;
   logic       ce;
   logic       co_n;

   modport master (
      input  opcode,
      output step, halted, hlt, mi_n, ri_n, ro_n, ii_n, io_n, ai_n,
             ao_n, eo_n, su, bi_n, oi_n, ce, co_n
   );

   modport slave (
      output opcode,
      input  step, halted, hlt, mi_n, ri_n, ro_n, ii_n, io_n, ai_n,
             ao_n, eo_n, su, bi_n, oi_n, ce, co_n
   );
endinterface

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - T-state sequencer producing one bus control word per clock
module control_sequencer #(
   parameter int STEPS     = 5,
   parameter bit EARLY_END = 1'b1
) (
   input  logic                 clk,
   input  logic                 clr,
   control_sequencer_if.master  bus
);
   typedef enum logic {RUN, HALT} state_t;

   localparam logic [2:0] STEP_MAX = 3'(STEPS - 1);
   localparam logic [3:0] OP_LDA   = 4'b0000;
   localparam logic [3:0] OP_ADD   = 4'b0001;
   localparam logic [3:0] OP_SUB   = 4'b0010;
   localparam logic [3:0] OP_OUT   = 4'b1110;
   localparam logic [3:0] OP_HLT   = 4'b1111;

   state_t     state, state_next;
   logic [2:0] step, step_next;
   logic [2:0] last_step;

   logic hlt, mi_n, ro_n, ii_n, io_n, ai_n, ao_n, eo_n, su, bi_n, oi_n, ce, co_n;

   always_ff @(posedge clk) begin
      if (clr) begin
         state <= RUN;
         step  <= '0;
      end else begin
         state <= state_next;
         step  <= step_next;
      end
   end

   always_comb begin
      case (bus.opcode)
         OP_LDA:         last_step = 3'd3;
         OP_ADD, OP_SUB: last_step = 3'd4;
         OP_OUT, OP_HLT: last_step = 3'd2;
         default:        last_step = 3'd1;
      endcase
   end

   // The opcode is only trusted from T2 on, so an early return is never taken
   // before T2; a NOP therefore spends one idle T2 before refetching.
   always_comb begin
      state_next = state;
      step_next  = step;
      if (state == RUN) begin
         if (step == 3'd2 && bus.opcode == OP_HLT) begin
            state_next = HALT;
         end else if (step == STEP_MAX ||
                      (EARLY_END && step >= 3'd2 && step >= last_step)) begin
            step_next = '0;
         end else begin
            step_next = step + 3'd1;
         end
      end
   end

   always_comb begin
      hlt  = 1'b0;
      mi_n = 1'b1;
      ro_n = 1'b1;
      ii_n = 1'b1;
      io_n = 1'b1;
      ai_n = 1'b1;
      ao_n = 1'b1;
      eo_n = 1'b1;
      su   = 1'b0;
      bi_n = 1'b1;
      oi_n = 1'b1;
      ce   = 1'b0;
      co_n = 1'b1;
      if (!clr) begin
         if (state == HALT) begin
            hlt = 1'b1;
         end else if (step == 3'd0) begin
            co_n = 1'b0;
            mi_n = 1'b0;
         end else if (step == 3'd1) begin
            ro_n = 1'b0;
            ii_n = 1'b0;
            ce   = 1'b1;
         end else begin
            case (bus.opcode)
               OP_LDA: begin
                  if (step == 3'd2) begin io_n = 1'b0; mi_n = 1'b0; end
                  if (step == 3'd3) begin ro_n = 1'b0; ai_n = 1'b0; end
               end
               OP_ADD, OP_SUB: begin
                  if (step == 3'd2) begin io_n = 1'b0; mi_n = 1'b0; end
                  if (step == 3'd3) begin ro_n = 1'b0; bi_n = 1'b0; end
                  if (step == 3'd4) begin
                     eo_n = 1'b0;
                     ai_n = 1'b0;
                     su   = (bus.opcode == OP_SUB);
                  end
               end
               OP_OUT: begin
                  if (step == 3'd2) begin ao_n = 1'b0; oi_n = 1'b0; end
               end
               OP_HLT: begin
                  if (step == 3'd2) hlt = 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.step   = step;
   assign bus.halted = (state == HALT);
   assign bus.hlt    = hlt;
   assign bus.mi_n   = mi_n;
   assign bus.ri_n   = 1'b1;
   assign bus.ro_n   = ro_n;
   assign bus.ii_n   = ii_n;
   assign bus.io_n   = io_n;
   assign bus.ai_n   = ai_n;
   assign bus.ao_n   = ao_n;
   assign bus.eo_n   = eo_n;
   assign bus.su     = su;
   assign bus.bi_n   = bi_n;
   assign bus.oi_n   = oi_n;
   assign bus.ce     = ce;
   assign bus.co_n   = co_n;
endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - vector-table bench for both EARLY_END settings of control_sequencer
module tb_control_sequencer;
   // word layout: hlt mi ri ro ii io ai ao eo su bi oi ce co
   localparam logic [13:0] DEF   = 14'b01111111101101;
   localparam logic [13:0] M_HLT = 14'd1 << 13;
   localparam logic [13:0] M_MI  = 14'd1 << 12;
   localparam logic [13:0] M_RO  = 14'd1 << 10;
   localparam logic [13:0] M_II  = 14'd1 << 9;
   localparam logic [13:0] M_IO  = 14'd1 << 8;
   localparam logic [13:0] M_AI  = 14'd1 << 7;
   localparam logic [13:0] M_AO  = 14'd1 << 6;
   localparam logic [13:0] M_EO  = 14'd1 << 5;
   localparam logic [13:0] M_SU  = 14'd1 << 4;
   localparam logic [13:0] M_BI  = 14'd1 << 3;
   localparam logic [13:0] M_OI  = 14'd1 << 2;
   localparam logic [13:0] M_CE  = 14'd1 << 1;
   localparam logic [13:0] M_CO  = 14'd1 << 0;
   localparam logic [13:0] W_T0  = DEF ^ (M_CO | M_MI);
   localparam logic [13:0] W_T1  = DEF ^ (M_RO | M_II | M_CE);
   localparam logic [13:0] W_OPM = DEF ^ (M_IO | M_MI);

   typedef struct {
      logic        sel;
      logic        chk;
      logic        clr;
      logic [3:0]  op;
      logic [2:0]  step;
      logic        halted;
      logic [13:0] word;
   } vec_t;

   logic       clk = 1'b0;
   logic       clr = 1'b1;
   logic [3:0] opcode = 4'd0;
   int         passed = 0;
   int         total = 0;
   int         hold_idx = 0;
   vec_t       vt[$];

   control_sequencer_if ee();
   control_sequencer_if fl();
   assign ee.opcode = opcode;
   assign fl.opcode = opcode;

   control_sequencer #(.STEPS(5), .EARLY_END(1'b1)) dut_e (.clk(clk), .clr(clr), .bus(ee.master));
   control_sequencer #(.STEPS(5), .EARLY_END(1'b0)) dut_f (.clk(clk), .clr(clr), .bus(fl.master));

   always #5 clk = ~clk;

   logic [13:0] w_e, w_f;
   assign w_e = {ee.hlt, ee.mi_n, ee.ri_n, ee.ro_n, ee.ii_n, ee.io_n, ee.ai_n,
                 ee.ao_n, ee.eo_n, ee.su, ee.bi_n, ee.oi_n, ee.ce, ee.co_n};
   assign w_f = {fl.hlt, fl.mi_n, fl.ri_n, fl.ro_n, fl.ii_n, fl.io_n, fl.ai_n,
                 fl.ao_n, fl.eo_n, fl.su, fl.bi_n, fl.oi_n, fl.ce, fl.co_n};

   task automatic check(input string name, input int idx, input logic [13:0] act, input logic [13:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s row %0d: got %b expected %b", name, idx, act, exp);
   endtask

   task automatic add(input logic sel, input logic chk, input logic c, input logic [3:0] op,
                      input logic [2:0] s, input logic h, input logic [13:0] w);
      vec_t v;
      v.sel = sel; v.chk = chk; v.clr = c; v.op = op; v.step = s; v.halted = h; v.word = w;
      vt.push_back(v);
   endtask

   task automatic drive(input logic c, input logic [3:0] op);
      @(negedge clk);
      clr    = c;
      opcode = op;
      #1;
   endtask

   function automatic logic inv_ok(input logic [13:0] w);
      int drivers;
      drivers = int'(!w[0]) + int'(!w[10]) + int'(!w[8]) + int'(!w[6]) + int'(!w[5]);
      return (drivers <= 1) && !(!w[7] && !w[6]) && !(!w[9] && !w[8]) && !(!w[11] && !w[10]);
   endfunction

   initial begin
      // early-end DUT: reset, ADD, SUB, LDA, OUT, HLT
      add(0, 1, 1, 4'h1, 3'd0, 0, DEF);
      add(0, 1, 1, 4'h1, 3'd0, 0, DEF);
      add(0, 1, 0, 4'h1, 3'd0, 0, W_T0);
      add(0, 1, 0, 4'h1, 3'd1, 0, W_T1);
      add(0, 1, 0, 4'h1, 3'd2, 0, W_OPM);
      add(0, 1, 0, 4'h1, 3'd3, 0, DEF ^ (M_RO | M_BI));
      add(0, 1, 0, 4'h1, 3'd4, 0, DEF ^ (M_EO | M_AI));
      add(0, 1, 0, 4'h2, 3'd0, 0, W_T0);
      add(0, 1, 0, 4'h2, 3'd1, 0, W_T1);
      add(0, 1, 0, 4'h2, 3'd2, 0, W_OPM);
      add(0, 1, 0, 4'h2, 3'd3, 0, DEF ^ (M_RO | M_BI));
      add(0, 1, 0, 4'h2, 3'd4, 0, DEF ^ (M_EO | M_AI | M_SU));
      add(0, 1, 0, 4'h0, 3'd0, 0, W_T0);
      add(0, 1, 0, 4'h0, 3'd1, 0, W_T1);
      add(0, 1, 0, 4'h0, 3'd2, 0, W_OPM);
      add(0, 1, 0, 4'h0, 3'd3, 0, DEF ^ (M_RO | M_AI));
      add(0, 1, 0, 4'h0, 3'd0, 0, W_T0);
      add(0, 1, 0, 4'hE, 3'd1, 0, W_T1);
      add(0, 1, 0, 4'hE, 3'd2, 0, DEF ^ (M_AO | M_OI));
      add(0, 1, 0, 4'hE, 3'd0, 0, W_T0);
      add(0, 1, 0, 4'hF, 3'd1, 0, W_T1);
      add(0, 1, 0, 4'hF, 3'd2, 0, DEF ^ M_HLT);
      add(0, 1, 0, 4'hF, 3'd2, 1, DEF ^ M_HLT);
      hold_idx = vt.size();
      // clr out of halt, then clr in T3 of ADD
      add(0, 1, 1, 4'h1, 3'd2, 1, DEF);
      add(0, 1, 0, 4'h1, 3'd0, 0, W_T0);
      add(0, 1, 0, 4'h1, 3'd1, 0, W_T1);
      add(0, 1, 0, 4'h1, 3'd2, 0, W_OPM);
      add(0, 1, 1, 4'h1, 3'd3, 0, DEF);
      add(0, 1, 0, 4'h1, 3'd0, 0, W_T0);
      add(0, 1, 0, 4'h1, 3'd1, 0, W_T1);
      // full-length DUT: NOP then LDA run all five steps
      add(1, 0, 1, 4'h6, 3'd0, 0, DEF);
      add(1, 1, 1, 4'h6, 3'd0, 0, DEF);
      add(1, 1, 0, 4'h6, 3'd0, 0, W_T0);
      add(1, 1, 0, 4'h6, 3'd1, 0, W_T1);
      add(1, 1, 0, 4'h6, 3'd2, 0, DEF);
      add(1, 1, 0, 4'h6, 3'd3, 0, DEF);
      add(1, 1, 0, 4'h6, 3'd4, 0, DEF);
      add(1, 1, 0, 4'h0, 3'd0, 0, W_T0);
      add(1, 1, 0, 4'h0, 3'd1, 0, W_T1);
      add(1, 1, 0, 4'h0, 3'd2, 0, W_OPM);
      add(1, 1, 0, 4'h0, 3'd3, 0, DEF ^ (M_RO | M_AI));
      add(1, 1, 0, 4'h0, 3'd4, 0, DEF);
      add(1, 1, 0, 4'h0, 3'd0, 0, W_T0);

      clr = 1'b1;
      repeat (2) @(posedge clk);

      for (int i = 0; i < vt.size(); i++) begin
         if (i == hold_idx) begin
            for (int k = 0; k < 20; k++) begin
               drive(1'b0, 4'h1);
               check("halt_step", k, 14'(ee.step), 14'd2);
               check("halt_word", k, w_e, DEF ^ M_HLT);
            end
         end
         drive(vt[i].clr, vt[i].op);
         if (vt[i].chk) begin
            if (vt[i].sel == 1'b0) begin
               check("step", i, 14'(ee.step), 14'(vt[i].step));
               check("halted", i, 14'(ee.halted), 14'(vt[i].halted));
               check("word", i, w_e, vt[i].word);
            end else begin
               check("step_full", i, 14'(fl.step), 14'(vt[i].step));
               check("halted_full", i, 14'(fl.halted), 14'(vt[i].halted));
               check("word_full", i, w_f, vt[i].word);
            end
         end
      end

      for (int k = 0; k < 300; k++) begin
         drive(($urandom_range(0, 15) == 0), 4'($urandom_range(0, 15)));
         check("invariant_e", k, 14'(inv_ok(w_e)), 14'd1);
         check("invariant_f", k, 14'(inv_ok(w_f)), 14'd1);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
